serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing d = a - b - bi over WIDTH clock cycles, LSB first.
- Uses a single registered full-subtractor cell with a borrow flip-flop, the inverse arithmetic of the team's registered full-adder cell.
- Used as a low-area subtract path in datapaths where latency is acceptable.
- Start/busy/done handshake; the result is held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- ck  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- bi  input  1  borrow-in; captured on the accepted start edge.
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse; d, bo and ovf are valid from this cycle onward.
- d  output  WIDTH  difference, registered, held until the next accepted start.
- bo  output  1  borrow-out (1 means unsigned a < b + bi), held like d.
- d_ser  output  1  current serial difference bit, registered.
- d_ser_vld  output  1  high in each cycle where d_ser carries a new bit.
- ovf  output  1  signed overflow flag (see Optional Feature).

Behaviour:
- Clock and reset: one clock, ck. Reset is synchronous and active-high, on rst.
- Reset values: all outputs 0; state IDLE; shift registers, borrow flip-flop and bit counter all 0.
- FSM has two states, IDLE and RUN.
  - IDLE: start=1 at an edge loads sa<=a, sb<=b and br<=bi, clears cnt, clears d/bo/ovf, and moves to RUN. busy=1 from the next cycle.
  - RUN: each edge computes one bit from x=sa[0], y=sb[0]:
    - diff = x^y^br
    - br <= (~x&y) | (~(x^y)&br)
    - d shifts right with diff entering at the MSB
    - sa and sb shift right
    - d_ser <= diff, d_ser_vld <= 1
    - cnt <= cnt+1
  - RUN, edge where cnt==WIDTH-1: processes the MSB bit as above, then bo <= new borrow, done <= 1 for one cycle, busy <= 0, returns to IDLE.
- Latency: start accepted at edge 0 gives RUN edges 1..WIDTH. done and busy=0 are visible after edge WIDTH, i.e. WIDTH cycles after acceptance.
- d holds partial results during RUN. d is only valid when done=1 or afterward in IDLE.
- start while busy=1: ignored, no queuing.
- start in the same cycle as done (state IDLE): accepted. d/bo/ovf clear on the following edge.
- a, b and bi are don't-care except on the accepted start edge.
- rst mid-RUN: next edge returns everything to reset values. No done is produced and the operation is abandoned.
- rst together with start: rst wins.
- Wrap-around: the result is modulo 2^WIDTH, and bo reports the unsigned underflow.
- d_ser_vld is low in IDLE and high for exactly WIDTH consecutive cycles per operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: at the final RUN edge, ovf <= (a_msb != b_msb) && (diff_msb != a_msb). a_msb and b_msb are the captured MSBs, which stay in extra registers. ovf is held with d and cleared on start or rst.
- Undefined: ovf is tied to 0 and the MSB capture registers are not built.

Test Plan:
- WIDTH=8: a=0x35, b=0x12, bi=0, start 1 cycle. Expect:
  - busy=1 for 8 cycles, then done pulse.
  - d=0x23, bo=0.
  - d_ser sequence LSB-first 1,1,0,0,0,1,0,0.
- a=0x00, b=0x01, bi=0 -> d=0xFF, bo=1, ovf=0.
- a=0x10, b=0x0F, bi=1 -> d=0x00, bo=0; then a=0x00, b=0x00, bi=1 -> d=0xFF, bo=1.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 -> d=0x7F, ovf=1.
  - a=0x7F, b=0xFF -> d=0x80, ovf=1, bo=1.
  - Without the macro: ovf is always 0.
- Start a=0x35, b=0x12; pulse start again with a=0xFF at RUN cycle 2 -> ignored, result still 0x23. Pulse start in the done cycle with a=0x05, b=0x03 -> accepted, d=0x02 after 8 more cycles.
- Assert rst at RUN cycle 3 -> next cycle busy=0, d=0, d_ser_vld=0, no done pulse. A new start then completes normally.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The requester side uses the master modport, the subtractor uses slave.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
  logic             d_ser;
  logic             d_ser_vld;
  logic             ovf;

  modport master (
    output start, a, b, bi,
    input  busy, done, d, bo, d_ser, d_ser_vld, ovf
  );

  modport slave (
    input  start, a, b, bi,
    output busy, done, d, bo, d_ser, d_ser_vld, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: d = a - b - bi, LSB first,
// one bit per clock through a single full-subtractor cell and a borrow
// flip-flop. Optional signed overflow detection is built when the macro
// SERIAL_SUB_OVF_EN is defined; otherwise ovf is tied low.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                ck,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q;
  logic             busy_q;
  logic             done_q;
  logic             dSer_q;
  logic             dSerVld_q;

  logic             diffBit_d;
  logic             borrow_d;

`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
  logic             aMsb_q;
  logic             bMsb_q;
`endif

  // Full-subtractor cell operating on the current LSBs and stored borrow
  always_comb begin
    diffBit_d = shiftA_q[0] ^ shiftB_q[0] ^ borrow_q;
    borrow_d  = (~shiftA_q[0] & shiftB_q[0]) |
                (~(shiftA_q[0] ^ shiftB_q[0]) & borrow_q);
  end

  // Control FSM and serial datapath with registered handshake outputs
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= IDLE;
      shiftA_q  <= '0;
      shiftB_q  <= '0;
      borrow_q  <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bo_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dSer_q    <= 1'b0;
      dSerVld_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q     <= 1'b0;
      aMsb_q    <= 1'b0;
      bMsb_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dSerVld_q <= 1'b0;
          if (bus.start) begin
            shiftA_q <= bus.a;
            shiftB_q <= bus.b;
            borrow_q <= bus.bi;
            cnt_q    <= '0;
            diff_q   <= '0;
            bo_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
            aMsb_q   <= bus.a[WIDTH-1];
            bMsb_q   <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          borrow_q  <= borrow_d;
          diff_q    <= {diffBit_d, diff_q[WIDTH-1:1]};
          shiftA_q  <= shiftA_q >> 1;
          shiftB_q  <= shiftB_q >> 1;
          dSer_q    <= diffBit_d;
          dSerVld_q <= 1'b1;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bo_q    <= borrow_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= (aMsb_q != bMsb_q) && (diffBit_d != aMsb_q);
`endif
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.d         = diff_q;
  assign bus.bo        = bo_q;
  assign bus.d_ser     = dSer_q;
  assign bus.d_ser_vld = dSerVld_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  assign bus.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, handshake
// corner cases and randomized operands against an arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 8;

  logic ck;
  logic rst;
  int   tests;
  int   failures;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bi, output logic [W-1:0] d,
                                   output logic bo, output logic ov);
    int ua, ub, diff, sa, sb, sd;
    ua   = int'(a);
    ub   = int'(b);
    diff = ua - ub - int'(bi);
    d    = W'(diff);
    bo   = (diff < 0);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    sd   = sa - sb - int'(bi);
`ifdef SERIAL_SUB_OVF_EN
    ov   = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
`else
    ov   = (sd != sd);
`endif
  endfunction

  logic [W-1:0] lastD;

  // One full operation; injectAt >= 0 pulses start with junk during RUN
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bi, input int injectAt);
    logic [W-1:0] expD;
    logic         expBo;
    logic         expOv;
    logic [W-1:0] serWord;
    refModel(a, b, bi, expD, expBo, expOv);
    serWord   = '0;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bi    = bi;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bi    = 1'($urandom);
    checkOutput("d_clr", 32'(bus.d), 32'(0));
    checkOutput("bo_clr", 32'(bus.bo), 32'(0));
    checkOutput("ovf_clr", 32'(bus.ovf), 32'(0));
    for (int i = 0; i < W; i++) begin
      if (i == injectAt) begin
        bus.start = 1'b1;
        bus.a     = '1;
      end else begin
        bus.start = 1'b0;
      end
      checkOutput("busy_run", 32'(bus.busy), 32'(1));
      checkOutput("done_early", 32'(bus.done), 32'(0));
      tick();
      checkOutput("ser_vld", 32'(bus.d_ser_vld), 32'(1));
      serWord[i] = bus.d_ser;
    end
    bus.start = 1'b0;
    checkOutput("done", 32'(bus.done), 32'(1));
    checkOutput("busy_end", 32'(bus.busy), 32'(0));
    checkOutput("d", 32'(bus.d), 32'(expD));
    checkOutput("bo", 32'(bus.bo), 32'(expBo));
    checkOutput("ovf", 32'(bus.ovf), 32'(expOv));
    checkOutput("ser_word", 32'(serWord), 32'(expD));
    lastD = expD;
  endtask

  // One idle cycle after completion: pulse gone, result held
  task automatic idleCheck();
    tick();
    checkOutput("done_pulse", 32'(bus.done), 32'(0));
    checkOutput("vld_idle", 32'(bus.d_ser_vld), 32'(0));
    checkOutput("d_hold", 32'(bus.d), 32'(lastD));
    checkOutput("busy_idle", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    tests     = 0;
    failures  = 0;
    lastD     = '0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h11;
    bus.bi    = 1'b0;
    tick();
    tick();
    checkOutput("rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("rst_done", 32'(bus.done), 32'(0));
    checkOutput("rst_d", 32'(bus.d), 32'(0));
    checkOutput("rst_bo", 32'(bus.bo), 32'(0));
    checkOutput("rst_ser", 32'(bus.d_ser), 32'(0));
    checkOutput("rst_vld", 32'(bus.d_ser_vld), 32'(0));
    checkOutput("rst_ovf", 32'(bus.ovf), 32'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(bus.busy), 32'(0));

    // Directed vectors
    applyStimulus(8'h35, 8'h12, 1'b0, -1);
    checkOutput("tp_d_0x23", 32'(bus.d), 32'(8'h23));
    idleCheck();
    applyStimulus(8'h00, 8'h01, 1'b0, -1);
    checkOutput("tp_bo_under", 32'(bus.bo), 32'(1));
    idleCheck();
    applyStimulus(8'h10, 8'h0F, 1'b1, -1);
    applyStimulus(8'h00, 8'h00, 1'b1, -1);
    applyStimulus(8'h80, 8'h01, 1'b0, -1);
    applyStimulus(8'h7F, 8'hFF, 1'b0, -1);
    idleCheck();

    // Start during RUN is ignored; start in the done cycle is accepted
    applyStimulus(8'h35, 8'h12, 1'b0, 2);
    applyStimulus(8'h05, 8'h03, 1'b0, -1);
    checkOutput("b2b_d", 32'(bus.d), 32'(8'h02));
    idleCheck();

    // Reset in the middle of an operation abandons it
    bus.start = 1'b1;
    bus.a     = 8'hA5;
    bus.b     = 8'h3C;
    bus.bi    = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'(0));
    checkOutput("mid_rst_d", 32'(bus.d), 32'(0));
    checkOutput("mid_rst_vld", 32'(bus.d_ser_vld), 32'(0));
    for (int i = 0; i < W + 2; i++) begin
      checkOutput("mid_rst_nodone", 32'(bus.done), 32'(0));
      tick();
    end
    applyStimulus(8'h35, 8'h12, 1'b0, -1);
    idleCheck();

    // Randomized operands, sometimes back-to-back, sometimes with idle gaps
    for (int n = 0; n < 40; n++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 1) idleCheck();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
